// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and frame constants for the program loader
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = BYTE_W * WORD_BYTES;
   localparam int LEN_BYTES  = 2;
   localparam int LEN_W      = BYTE_W * LEN_BYTES;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction cache write port and status out
interface program_loader_if #(
   parameter int COUNT_WIDTH = 16
) ();

   logic                   start;
   logic                   byteValid;
   logic [7:0]             byteData;
   logic                   byteReady;
   logic                   writeEnable;
   logic [31:0]            writeAddress;
   logic [31:0]            writeData;
   logic                   cpuHold;
   logic                   done;
   logic                   error;
   logic [COUNT_WIDTH-1:0] wordsWritten;

   modport master (
      output start, byteValid, byteData,
      input  byteReady, writeEnable, writeAddress, writeData,
      input  cpuHold, done, error, wordsWritten
   );

   modport slave (
      input  start, byteValid, byteData,
      output byteReady, writeEnable, writeAddress, writeData,
      output cpuHold, done, error, wordsWritten
   );

endinterface

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - little-endian byte-to-word packer with running XOR checksum
module word_assembler
   import program_loader_pkg::*;
(
   input  logic              clock,
   input  logic              resetN,
   input  logic              clear,
   input  logic              enable,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_next,
   output logic [BYTE_W-1:0] checksum,
   output logic              word_last
);

   logic [WORD_W-1:0] word;
   logic [1:0]        byte_index;

   // word_next lets the caller latch the finished word on the same edge as its last byte
   always_comb begin
      word_next = word;
      word_next[BYTE_W*byte_index +: BYTE_W] = byte_in;
   end

   assign word_last = (byte_index == 2'(WORD_BYTES - 1));

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         word       <= '0;
         byte_index <= '0;
         checksum   <= '0;
      end else if (clear) begin
         word       <= '0;
         byte_index <= '0;
         checksum   <= '0;
      end else if (enable) begin
         word       <= word_next;
         byte_index <= byte_index + 2'd1;
         checksum   <= checksum ^ byte_in;
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a checksummed frame into the instruction cache and holds the CPU meanwhile
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          DEPTH       = 256,
   parameter int          COUNT_WIDTH = 16
) (
   input logic             clock,
   input logic             resetN,
   program_loader_if.slave bus
);

   localparam logic [COUNT_WIDTH-1:0] DEPTH_W = COUNT_WIDTH'(DEPTH);
   localparam logic [COUNT_WIDTH-1:0] ONE_W   = COUNT_WIDTH'(1);

   state_t                  state;
   logic [BYTE_W-1:0]       len_lo;
   logic [LEN_W-1:0]        len_field;
   logic [COUNT_WIDTH-1:0]  frame_len;
   logic [COUNT_WIDTH-1:0]  word_count;
   logic [COUNT_WIDTH-1:0]  word_index;
   logic [31:0]             word_addr;
   logic                    xfer;
   logic                    start_ok;
   logic                    asm_enable;
   logic [WORD_W-1:0]       word_next;
   logic [BYTE_W-1:0]       checksum;
   logic                    word_last;

   assign xfer       = bus.byteValid && bus.byteReady;
   assign start_ok   = bus.start && (state == IDLE || state == DONE || state == ERROR);
   assign asm_enable = xfer && (state == DATA);
   assign len_field  = {bus.byteData, len_lo};
   assign frame_len  = COUNT_WIDTH'(len_field);
   assign word_addr  = BASE_ADDR + 32'(word_index) * 32'(WORD_BYTES);

   word_assembler u_word_assembler (
      .clock     (clock),
      .resetN    (resetN),
      .clear     (start_ok),
      .enable    (asm_enable),
      .byte_in   (bus.byteData),
      .word_next (word_next),
      .checksum  (checksum),
      .word_last (word_last)
   );

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state            <= IDLE;
         len_lo           <= '0;
         word_count       <= '0;
         word_index       <= '0;
         bus.byteReady    <= 1'b0;
         bus.writeEnable  <= 1'b0;
         bus.writeAddress <= BASE_ADDR;
         bus.writeData    <= '0;
         bus.cpuHold      <= 1'b1;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
         bus.wordsWritten <= '0;
      end else begin
         bus.writeEnable <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start_ok) begin
                  state            <= LEN_LO;
                  bus.byteReady    <= 1'b1;
                  bus.cpuHold      <= 1'b1;
                  bus.done         <= 1'b0;
                  bus.error        <= 1'b0;
                  bus.wordsWritten <= '0;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len_lo <= bus.byteData;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  if (frame_len == '0 || frame_len > DEPTH_W) begin
                     state         <= ERROR;
                     bus.byteReady <= 1'b0;
                     bus.error     <= 1'b1;
                  end else begin
                     word_count <= frame_len;
                     word_index <= '0;
                     state      <= DATA;
                  end
               end
            end
            DATA: begin
               // Register the write-port outputs on the edge that takes the 4th byte
               if (xfer && word_last) begin
                  state            <= WRITE;
                  bus.byteReady    <= 1'b0;
                  bus.writeEnable  <= 1'b1;
                  bus.writeAddress <= word_addr;
                  bus.writeData    <= word_next;
               end
            end
            WRITE: begin
               bus.wordsWritten <= word_index + ONE_W;
               bus.byteReady    <= 1'b1;
               if (word_index + ONE_W == word_count) begin
                  state <= CHECK;
               end else begin
                  word_index <= word_index + ONE_W;
                  state      <= DATA;
               end
            end
            CHECK: begin
               if (xfer) begin
                  bus.byteReady <= 1'b0;
                  if (bus.byteData == checksum) begin
                     state       <= DONE;
                     bus.done    <= 1'b1;
                     bus.cpuHold <= 1'b0;
                  end else begin
                     state     <= ERROR;
                     bus.error <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven frame loads with a write scoreboard plus reset/restart sequences
module tb_program_loader;

   typedef struct {
      logic [127:0] stream;
      int           nbytes;
      int           gap;
      int           nwr;
      logic [31:0]  w0;
      logic [31:0]  w1;
      logic         exp_done;
      logic         exp_error;
      logic         exp_hold;
      int           exp_words;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic resetN;
   int   checks;
   int   errors;
   int   writes_seen;
   logic we_prev;
   wr_t  sbq[$];
   vec_t tbl[6];

   program_loader_if #(.COUNT_WIDTH(16)) ifc ();

   program_loader #(
      .BASE_ADDR   (32'h0),
      .DEPTH       (256),
      .COUNT_WIDTH (16)
   ) dut (
      .clock  (clk),
      .resetN (resetN),
      .bus    (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the next expected (address, word)
   always @(negedge clk) begin
      if (resetN && ifc.writeEnable) begin
         writes_seen++;
         chk("we_one_cycle", {31'b0, we_prev}, 32'h0);
         chk("ready_low_in_write", {31'b0, ifc.byteReady}, 32'h0);
         if (sbq.size() == 0) begin
            chk("unexpected_write", ifc.writeAddress, 32'hFFFF_FFFF);
         end else begin
            chk("write_addr", ifc.writeAddress, sbq[0].addr);
            chk("write_data", ifc.writeData, sbq[0].data);
            void'(sbq.pop_front());
         end
      end
      we_prev = ifc.writeEnable;
   end

   task automatic pulse_start();
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      chk("start_ready", {31'b0, ifc.byteReady}, 32'h1);
      chk("start_done", {31'b0, ifc.done}, 32'h0);
      chk("start_error", {31'b0, ifc.error}, 32'h0);
      chk("start_hold", {31'b0, ifc.cpuHold}, 32'h1);
      chk("start_words", 32'(ifc.wordsWritten), 32'h0);
   endtask

   task automatic send_frame(input vec_t v);
      logic acc;
      int   n;
      for (int i = 0; i < v.nbytes; i++) begin
         if (i > 0) repeat (v.gap) @(negedge clk);
         ifc.byteValid = 1'b1;
         ifc.byteData  = v.stream[127 - 8*i -: 8];
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 20) begin
            acc = ifc.byteReady;
            @(negedge clk);
            n++;
         end
         ifc.byteValid = 1'b0;
         if (!acc) begin
            chk("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
            return;
         end
      end
   endtask

   task automatic run_case(input int k);
      vec_t v;
      int   base_seen;
      v = tbl[k];
      if (v.nwr > 0) sbq.push_back('{addr: 32'h0, data: v.w0});
      if (v.nwr > 1) sbq.push_back('{addr: 32'h4, data: v.w1});
      base_seen = writes_seen;
      pulse_start();
      send_frame(v);
      repeat (2) @(negedge clk);
      chk("final_done", {31'b0, ifc.done}, {31'b0, v.exp_done});
      chk("final_error", {31'b0, ifc.error}, {31'b0, v.exp_error});
      chk("final_hold", {31'b0, ifc.cpuHold}, {31'b0, v.exp_hold});
      chk("final_words", 32'(ifc.wordsWritten), 32'(v.exp_words));
      chk("final_ready", {31'b0, ifc.byteReady}, 32'h0);
      chk("write_count", 32'(writes_seen - base_seen), 32'(v.nwr));
      chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
      sbq.delete();
   endtask

   initial begin
      vec_t part;
      checks      = 0;
      errors      = 0;
      writes_seen = 0;
      we_prev     = 1'b0;
      ifc.start     = 1'b0;
      ifc.byteValid = 1'b0;
      ifc.byteData  = 8'h00;

      tbl[0] = '{{88'h02002000028B410003CB20, 40'h0}, 11, 0, 2, 32'h8B020020, 32'hCB030041, 1'b1, 1'b0, 1'b0, 2};
      tbl[1] = '{{88'h02002000028B410003CB20, 40'h0}, 11, 3, 2, 32'h8B020020, 32'hCB030041, 1'b1, 1'b0, 1'b0, 2};
      tbl[2] = '{{16'h0000, 112'h0}, 2, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0};
      tbl[3] = '{{16'h0101, 112'h0}, 2, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0};
      tbl[4] = '{{88'h02002000028B410003CB21, 40'h0}, 11, 0, 2, 32'h8B020020, 32'hCB030041, 1'b0, 1'b1, 1'b1, 2};
      tbl[5] = '{{56'h01001300009182, 72'h0}, 7, 0, 1, 32'h91000013, 32'h0, 1'b1, 1'b0, 1'b0, 1};

      resetN = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hold", {31'b0, ifc.cpuHold}, 32'h1);
      chk("rst_ready", {31'b0, ifc.byteReady}, 32'h0);
      chk("rst_we", {31'b0, ifc.writeEnable}, 32'h0);
      chk("rst_done", {31'b0, ifc.done}, 32'h0);
      chk("rst_error", {31'b0, ifc.error}, 32'h0);
      chk("rst_addr", ifc.writeAddress, 32'h0);
      chk("rst_data", ifc.writeData, 32'h0);
      chk("rst_words", 32'(ifc.wordsWritten), 32'h0);
      resetN = 1'b1;

      run_case(0);
      run_case(5);
      run_case(1);
      run_case(2);
      run_case(3);
      run_case(4);

      // Mid-frame reset: the first word lands, then an async reset abandons the frame
      part = tbl[0];
      part.nbytes = 6;
      sbq.push_back('{addr: 32'h0, data: 32'h8B020020});
      pulse_start();
      send_frame(part);
      #2;
      resetN = 1'b0;
      #1;
      chk("arst_hold", {31'b0, ifc.cpuHold}, 32'h1);
      chk("arst_ready", {31'b0, ifc.byteReady}, 32'h0);
      chk("arst_we", {31'b0, ifc.writeEnable}, 32'h0);
      chk("arst_data", ifc.writeData, 32'h0);
      chk("arst_addr", ifc.writeAddress, 32'h0);
      chk("arst_words", 32'(ifc.wordsWritten), 32'h0);
      chk("arst_first_word", 32'(sbq.size()), 32'h0);
      sbq.delete();
      @(negedge clk);
      resetN = 1'b1;
      run_case(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
